// File: rtl/frame_relay_pkg.sv
// Shared types and trailer layout for the frame relay datapath.
package frame_relay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    localparam logic [31:0] TRAILER_MAGIC = 32'hA5A5_5A5A;

    localparam int TRL_MAGIC_LANE = 0;
    localparam int TRL_CSUM_LANE  = 1;
    localparam int TRL_COUNT_LANE = 2;
    localparam int TRL_INDEX_LANE = 3;
    localparam int TRL_LANES      = 4;

    function automatic logic [32*TRL_LANES-1:0] pack_trailer(
        input logic [31:0] csum,
        input logic [31:0] count,
        input logic [31:0] index
    );
        logic [32*TRL_LANES-1:0] w;
        w = '0;
        w[32*TRL_MAGIC_LANE +: 32] = TRAILER_MAGIC;
        w[32*TRL_CSUM_LANE  +: 32] = csum;
        w[32*TRL_COUNT_LANE +: 32] = count;
        w[32*TRL_INDEX_LANE +: 32] = index;
        return w;
    endfunction

endpackage

// File: rtl/frame_relay_if.sv
// Upstream FIFO read port and downstream FIFO write port of the frame relay.
interface frame_relay_if #(
    parameter int DATA_W = 128
);
    logic              up_empty;
    logic              up_rd_en;
    logic [DATA_W-1:0] up_dout;
    logic              up_valid;
    logic              dn_prog_full;
    logic              dn_wr_en;
    logic [DATA_W-1:0] dn_din;

    modport master (
        input  up_empty,
        input  up_dout,
        input  up_valid,
        input  dn_prog_full,
        output up_rd_en,
        output dn_wr_en,
        output dn_din
    );

    modport slave (
        output up_empty,
        output up_dout,
        output up_valid,
        output dn_prog_full,
        input  up_rd_en,
        input  dn_wr_en,
        input  dn_din
    );
endinterface

// File: rtl/frame_relay_lane_adder.sv
// Adds a common addend to every 32-bit lane and sums the results; one register stage.
module lane_adder #(
    parameter int DATA_W = 128
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       addend,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_sum
);
    localparam int LANES = DATA_W / 32;

    logic [DATA_W-1:0] lane_word;
    logic [31:0]       lane_total;

    always_comb begin
        logic [31:0] lane_val;
        lane_word  = '0;
        lane_total = '0;
        lane_val   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_val                = in_data[32*i +: 32] + addend;
            lane_word[32*i +: 32]   = lane_val;
            lane_total              = lane_total + lane_val;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sum   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= lane_word;
                out_sum  <= lane_total;
            end
        end
    end
endmodule

// File: rtl/frame_relay.sv
// Streams cfg_len words from the upstream FIFO to the downstream FIFO with a
// per-lane addend, then appends a trailer word carrying checksum, count and index.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for cfg_en; latches length/addend on start
// ST_STREAM  | issuing reads and writing transformed payload words
// ST_TRAILER | waiting for downstream space to write the trailer word
module frame_relay
    import frame_relay_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             cfg_en,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [31:0]      cfg_add,
    frame_relay_if.master    bus,
    output logic             busy,
    output logic             frame_done,
    output logic [31:0]      frame_cnt
);
    localparam int LANES = DATA_W / 32;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  wr_cnt;
    logic [31:0]       add_q;
    logic [31:0]       csum;
    logic              start;
    logic              rd_fire;
    logic              pay_wr;
    logic              trl_fire;
    logic              wr_en_c;
    logic [DATA_W-1:0] din_c;
    logic              pay_valid;
    logic [DATA_W-1:0] pay_data;
    logic [31:0]       pay_sum;
    logic [32*TRL_LANES-1:0] trl_packed;
    logic [DATA_W-1:0] trl_word;

    lane_adder #(.DATA_W(DATA_W)) u_lane_adder (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (bus.up_valid),
        .in_data   (bus.up_dout),
        .addend    (add_q),
        .out_valid (pay_valid),
        .out_data  (pay_data),
        .out_sum   (pay_sum)
    );

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_en) begin
                    state_nxt = (cfg_len == '0) ? ST_TRAILER : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (wr_cnt == len_q) begin
                    state_nxt = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                if (!bus.dn_prog_full) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // All strobes are held off while rstn is low so nothing leaks from a discarded frame.
    always_comb begin
        busy     = (state != ST_IDLE);
        start    = (state == ST_IDLE) && cfg_en;
        rd_fire  = 1'b0;
        trl_fire = 1'b0;
        if (rstn) begin
            rd_fire  = (state == ST_STREAM) && !bus.up_empty && !bus.dn_prog_full
                       && (rd_cnt < len_q);
            trl_fire = (state == ST_TRAILER) && !bus.dn_prog_full;
        end
        pay_wr     = rstn && pay_valid;
        wr_en_c    = pay_wr || trl_fire;
        frame_done = trl_fire;
        din_c      = '0;
        if (pay_wr) begin
            din_c = pay_data;
        end else if (trl_fire) begin
            din_c = trl_word;
        end
    end

    always_comb begin
        trl_packed = pack_trailer(csum, 32'(wr_cnt), frame_cnt);
        trl_word   = '0;
        for (int i = 0; i < LANES && i < TRL_LANES; i++) begin
            trl_word[32*i +: 32] = trl_packed[32*i +: 32];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            len_q     <= '0;
            add_q     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            csum      <= '0;
            frame_cnt <= '0;
        end else begin
            if (start) begin
                len_q  <= cfg_len;
                add_q  <= cfg_add;
                rd_cnt <= '0;
                wr_cnt <= '0;
                csum   <= '0;
            end else begin
                if (rd_fire) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (pay_wr) begin
                    wr_cnt <= wr_cnt + 1'b1;
                    csum   <= csum + pay_sum;
                end
            end
            if (trl_fire) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    assign bus.up_rd_en = rd_fire;
    assign bus.dn_wr_en = wr_en_c;
    assign bus.dn_din   = din_c;
endmodule

// File: tb/tb_frame_relay.sv
// Randomized bench for frame_relay with a queue-based reference model and scoreboard.
module tb_frame_relay;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 16;
    localparam int LANES  = DATA_W / 32;
    localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;

    logic             sys_clk = 1'b0;
    logic             rstn    = 1'b0;
    logic             cfg_en  = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [31:0]      cfg_add = '0;
    logic             busy;
    logic             frame_done;
    logic [31:0]      frame_cnt;

    frame_relay_if #(.DATA_W(DATA_W)) bus ();

    frame_relay #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .sys_clk    (sys_clk),
        .rstn       (rstn),
        .cfg_en     (cfg_en),
        .cfg_len    (cfg_len),
        .cfg_add    (cfg_add),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                is_trl;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] up_q[$];
    int errors = 0, checks = 0;
    int model_idx = 0, done_cnt = 0, pay_cnt = 0;
    int empty_mode = 0, pf_mode = 0, frame_cyc = 0;
    bit tog = 0, rd_seen = 0, rd_d1 = 0, rd_d2 = 0;
    logic [DATA_W-1:0] last_trl = '0, last_pay = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Upstream FIFO (data one cycle after an accepted read) and downstream back-pressure.
    always @(posedge sys_clk) begin : fifo_p
        bit e;
        bit pf;
        #1;
        if (rd_seen && up_q.size() > 0) begin
            bus.up_valid = 1'b1;
            bus.up_dout  = up_q.pop_front();
        end else begin
            bus.up_valid = 1'b0;
            bus.up_dout  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        tog = ~tog;
        frame_cyc++;
        case (empty_mode)
            1:       e = tog;
            2:       e = ($urandom_range(0, 99) < 30);
            default: e = 1'b0;
        endcase
        bus.up_empty = (up_q.size() == 0) || e;
        case (pf_mode)
            1:       pf = (frame_cyc >= 3) && (frame_cyc <= 10);
            2:       pf = ($urandom_range(0, 99) < 20);
            default: pf = 1'b0;
        endcase
        bus.dn_prog_full = pf;
    end

    always @(negedge sys_clk) begin : cmp_p
        exp_t e;
        bit   pay;
        rd_seen = bus.up_rd_en;
        if (!rstn) begin
            rd_d1 = 1'b0;
            rd_d2 = 1'b0;
        end else begin
            if (bus.up_rd_en) chk("rd_flow", bus.up_empty | bus.dn_prog_full, '0);
            pay = 1'b0;
            if (bus.dn_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got %h expected no write", bus.dn_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("dn_din", bus.dn_din, e.data);
                    chk("frame_done", frame_done, e.is_trl);
                    pay = !e.is_trl;
                    if (e.is_trl) begin
                        done_cnt++;
                        last_trl = bus.dn_din;
                    end else begin
                        pay_cnt++;
                        last_pay = bus.dn_din;
                    end
                end
            end else begin
                chk("din_idle", bus.dn_din, '0);
                chk("done_idle", frame_done, '0);
            end
            chk("latency", pay, rd_d2);
            rd_d2 = rd_d1;
            rd_d1 = bus.up_rd_en;
        end
    end

    task automatic push_frame(input int len, input logic [31:0] add, input int dmode);
        logic [31:0]       cs;
        logic [31:0]       v;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] t;
        exp_t              e;
        cs = '0;
        for (int i = 0; i < len; i++) begin
            for (int l = 0; l < LANES; l++) begin
                v = (dmode == 0) ? 32'd0 : (dmode == 1) ? 32'd1 : $urandom();
                w[32*l +: 32] = v;
                t[32*l +: 32] = v + add;
                cs = cs + (v + add);
            end
            up_q.push_back(w);
            e.data   = t;
            e.is_trl = 1'b0;
            exp_q.push_back(e);
        end
        e.data   = {32'(model_idx), 32'(len), cs, MAGIC};
        e.is_trl = 1'b1;
        exp_q.push_back(e);
        model_idx++;
    endtask

    task automatic start_frame(input int len, input logic [31:0] add, input int dmode, input bit hold);
        push_frame(len, add, dmode);
        cfg_en  = 1'b1;
        cfg_len = LEN_W'(len);
        cfg_add = add;
        @(posedge sys_clk);
        #1;
        frame_cyc = 0;
        if (!hold) begin
            cfg_en  = 1'b0;
            cfg_len = LEN_W'($urandom());
            cfg_add = $urandom();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge sys_clk);
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words outstanding expected 0", exp_q.size());
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_rd", bus.up_rd_en, '0);
        chk("rst_wr", bus.dn_wr_en, '0);
        chk("rst_din", bus.dn_din, '0);
        chk("rst_busy", busy, '0);
        chk("rst_done", frame_done, '0);
        chk("rst_cnt", frame_cnt, '0);
        @(posedge sys_clk);
        #1;
        up_q.delete();
        exp_q.delete();
        model_idx = 0;
        cfg_en    = 1'b0;
        rstn      = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        int d0;
        logic [31:0] a;
        bus.up_empty     = 1'b1;
        bus.up_valid     = 1'b0;
        bus.up_dout      = '0;
        bus.dn_prog_full = 1'b0;
        do_reset();

        start_frame(4, 32'd1, 0, 0);
        wait_idle(200);
        chk("t037_trailer", last_trl, {32'd0, 32'd4, 32'd16, MAGIC});
        chk("t037_payload", last_pay, {4{32'h1}});
        chk("t037_done", done_cnt, 1);
        chk("t037_frame_cnt", frame_cnt, 1);

        start_frame(0, $urandom(), 2, 0);
        wait_idle(50);
        chk("t038_trailer", last_trl, {32'd1, 32'd0, 32'd0, MAGIC});

        pf_mode = 1;
        base = pay_cnt;
        start_frame(8, $urandom(), 2, 0);
        wait_idle(300);
        pf_mode = 0;
        chk("t039_payloads", pay_cnt - base, 8);
        chk("t039_count", last_trl[95:64], 32'd8);
        chk("t039_frame_cnt", frame_cnt, 3);

        empty_mode = 1;
        start_frame(16, 32'hFFFF_FFFF, 1, 0);
        wait_idle(500);
        empty_mode = 0;
        chk("t040_trailer", last_trl, {32'd3, 32'd16, 32'd0, MAGIC});
        chk("t040_payload", last_pay, '0);

        base = pay_cnt;
        d0   = done_cnt;
        start_frame(8, $urandom(), 2, 0);
        n = 0;
        while (pay_cnt < base + 3 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL t041_wait: got %0d words expected 3", pay_cnt - base);
        end
        @(posedge sys_clk);
        #1;
        do_reset();
        repeat (10) @(posedge sys_clk);
        #1;
        chk("t041_no_trailer", done_cnt, d0);
        start_frame(2, 32'd3, 0, 0);
        wait_idle(100);
        chk("t041_trailer", last_trl, {32'd0, 32'd2, 32'd24, MAGIC});

        do_reset();
        d0 = done_cnt;
        a  = $urandom();
        start_frame(6, 32'h1000_0001, 2, 1);
        repeat (3) @(posedge sys_clk);
        #1;
        push_frame(5, a, 2);
        cfg_add = a;
        cfg_len = LEN_W'(5);
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL t042_wait: got %0d frames expected 1", done_cnt - d0);
        end
        @(posedge sys_clk);
        #1;
        @(posedge sys_clk);
        #1;
        cfg_en = 1'b0;
        wait_idle(300);
        chk("t042_index", last_trl[127:96], 32'd1);
        chk("t042_frames", done_cnt - d0, 2);
        chk("t042_frame_cnt", frame_cnt, 2);

        for (int f = 0; f < 25; f++) begin
            empty_mode = $urandom_range(0, 2);
            pf_mode    = ($urandom_range(0, 1) == 1) ? 2 : 0;
            start_frame($urandom_range(0, 12), $urandom(), 2, 0);
            wait_idle(2000);
            chk("rand_frame_cnt", frame_cnt, model_idx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_relay.md
FRAME_RELAY -- requirements
Module: frame_relay

Interface
REQ-001 Parameter DATA_W, default 128, datapath width; SHALL be a multiple of 32 (LANES = DATA_W/32).
REQ-002 Parameter LEN_W, default 16, width of the frame-length configuration.
REQ-003 sys_clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 cfg_en  in  1  enable; a new frame starts only while high.
REQ-006 cfg_len  in  LEN_W  payload words per frame; sampled at frame start.
REQ-007 cfg_add  in  32  per-lane addend; sampled at frame start.
REQ-008 up_empty  in  1  upstream FIFO empty.
REQ-009 up_rd_en  out  1  upstream FIFO read strobe.
REQ-010 up_dout  in  DATA_W  upstream read data; meaningful when up_valid is high.
REQ-011 up_valid  in  1  upstream data valid, one cycle after an accepted up_rd_en.
REQ-012 dn_prog_full  in  1  downstream FIFO programmable-full; asserts with at least 4 free entries remaining.
REQ-013 dn_wr_en  out  1  downstream FIFO write strobe.
REQ-014 dn_din  out  DATA_W  downstream write data.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 frame_done  out  1  one-cycle pulse in the cycle the trailer word is written.
REQ-017 frame_cnt  out  32  number of completed frames, wrapping modulo 2^32.

Function
REQ-018 The FSM SHALL have three states: IDLE, STREAM and TRAILER.
REQ-019 IDLE->STREAM when cfg_en=1; cfg_len and cfg_add are latched in the same cycle, and the read and write counters are cleared.
REQ-020 IDLE->TRAILER directly when cfg_en=1 and cfg_len=0, producing an empty frame whose trailer has count 0 and checksum 0.
REQ-021 In STREAM, up_rd_en=1 iff up_empty=0, dn_prog_full=0 and reads issued < latched length; at most one read per cycle.
REQ-022 Each up_valid word SHALL be transformed as out lane i = up_dout lane i + cfg_add (mod 2^32) for every lane.
REQ-023 The transformed word SHALL appear on dn_din with dn_wr_en=1 exactly one cycle after up_valid; latency from up_rd_en to dn_wr_en is 2 cycles.
REQ-024 up_valid SHALL be accepted in any state; the block never drops a valid word.
REQ-025 checksum = sum mod 2^32 of all 32-bit lanes of every transformed payload word in the frame.
REQ-026 STREAM->TRAILER when words written = latched length.
REQ-027 In TRAILER, once dn_prog_full=0, the block SHALL write one word with lanes [31:0]=32'hA5A5_5A5A, [63:32]=checksum, [95:64]=payload word count, [127:96]=frame index (frame_cnt before increment). For DATA_W>128 the upper lanes are 0.
REQ-028 On the trailer write, frame_done pulses, frame_cnt increments and the FSM returns to IDLE.
REQ-029 While dn_prog_full=1, no new reads are issued; words already in flight are still written (the 4-entry margin absorbs them).
REQ-030 Deasserting cfg_en mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-031 Changes to cfg_len/cfg_add mid-frame SHALL have no effect until the next frame.
REQ-032 dn_din SHALL be 0 whenever dn_wr_en=0.

Reset
REQ-033 With rstn=0 at a clock edge: FSM=IDLE; up_rd_en, dn_wr_en, busy and frame_done = 0; dn_din, frame_cnt, checksum and all counters = 0.
REQ-034 Reset mid-frame SHALL discard the partial frame with no trailer; up_valid received during reset is ignored.

Structure
REQ-035 A shared package frame_relay_pkg SHALL hold the FSM state typedef, the TRAILER_MAGIC=32'hA5A5_5A5A constant and the trailer lane-offset constants.
REQ-036 A single sub-module lane_adder SHALL implement the LANES-wide per-lane add and the lane-sum reduction, registered once.

Verification
REQ-037 Reset, then cfg_len=4, cfg_add=1, four upstream words of 32'h0 per lane -> four outputs of 32'h1 per lane, then trailer {0, 4, 16, A5A5_5A5A}, frame_done pulses once.
REQ-038 cfg_len=0, cfg_en=1 -> no up_rd_en; a single trailer {frame_cnt, 0, 0, A5A5_5A5A}.
REQ-039 cfg_len=8 with dn_prog_full held high for cycles 3-10 -> no up_rd_en during the stall, no lost or duplicated words, output order preserved, 8 payload words plus trailer.
REQ-040 up_empty toggling every cycle, cfg_len=16, cfg_add=32'hFFFF_FFFF, input lanes 1 -> output lanes 0 (wrap), checksum 0.
REQ-041 rstn=0 after 3 of 8 words -> outputs cleared next cycle, no trailer; a following frame of 2 words reports frame index 0 and count 2.
REQ-042 Two back-to-back frames with cfg_add changed mid-frame 1 -> frame 1 uses the old addend; trailer indices are 0 and 1.
